// File: rtl/inc_arbiter.sv
// Turns synchronized button levels into one-hot increment pulses, granted round-robin one per clock.
// Build option: define INC_ARB_AUTOREPEAT_EN to enable hold-to-repeat (HOLD/REPEAT states, tick counters).
module inc_arbiter #(
  parameter int DIGITS       = 4,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2,
  parameter int TCNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIGITS-1:0] btn_in,
  input  logic              tick,
  output logic [DIGITS-1:0] inc_out,
  output logic              active_out,
  output logic              repeat_out
);

  localparam int RR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // In the single-shot build ST_HOLD plays the role of PRESSED.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } st_e;

  st_e               st_q [DIGITS];
  st_e               st_d [DIGITS];
  logic [DIGITS-1:0] btn_prev_q;
  logic [DIGITS-1:0] pend_q;
  logic [DIGITS-1:0] pend_d;
  logic [DIGITS-1:0] pend_set;
  logic [DIGITS-1:0] gnt_oh;
  logic [DIGITS-1:0] inc_q;
  logic [RR_W-1:0]   rr_q;
  logic [RR_W-1:0]   rr_d;
  logic [RR_W-1:0]   gnt_idx;
  logic [RR_W-1:0]   cand;
  logic              gnt_vld;
  logic              any_active;
  logic              any_repeat;
  logic              active_q;
  logic              repeat_q;

`ifdef INC_ARB_AUTOREPEAT_EN
  logic [TCNT_W-1:0] tcnt_q [DIGITS];
  logic [TCNT_W-1:0] tcnt_d [DIGITS];
`else
  logic unused_tick;
  localparam int unused_cfg = HOLD_TICKS + REPEAT_TICKS + TCNT_W;
  assign unused_tick = tick;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DIGITS; j++) begin
        st_q[j] <= ST_IDLE;
`ifdef INC_ARB_AUTOREPEAT_EN
        tcnt_q[j] <= '0;
`endif
      end
      // All-ones so a button already held at reset release is not taken as a press.
      btn_prev_q <= '1;
      pend_q     <= '0;
      rr_q       <= '0;
      inc_q      <= '0;
      active_q   <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      for (int j = 0; j < DIGITS; j++) begin
        st_q[j] <= st_d[j];
`ifdef INC_ARB_AUTOREPEAT_EN
        tcnt_q[j] <= tcnt_d[j];
`endif
      end
      btn_prev_q <= btn_in;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      inc_q      <= gnt_oh;
      active_q   <= any_active;
      repeat_q   <= any_repeat;
    end
  end

  // Next-state: per-digit FSMs; release beats tick in the same cycle.
  always_comb begin
    pend_set = '0;
    for (int j = 0; j < DIGITS; j++) begin
      st_d[j] = st_q[j];
`ifdef INC_ARB_AUTOREPEAT_EN
      tcnt_d[j] = tcnt_q[j];
`endif
      case (st_q[j])
        ST_IDLE: begin
          if (btn_in[j] && !btn_prev_q[j]) begin
            st_d[j]     = ST_HOLD;
            pend_set[j] = 1'b1;
`ifdef INC_ARB_AUTOREPEAT_EN
            tcnt_d[j] = '0;
`endif
          end
        end
        ST_HOLD: begin
          if (!btn_in[j]) begin
            st_d[j] = ST_IDLE;
          end
`ifdef INC_ARB_AUTOREPEAT_EN
          else if (tick) begin
            if (tcnt_q[j] == TCNT_W'(HOLD_TICKS - 1)) begin
              st_d[j]     = ST_REPEAT;
              tcnt_d[j]   = '0;
              pend_set[j] = 1'b1;
            end else begin
              tcnt_d[j] = tcnt_q[j] + TCNT_W'(1);
            end
          end
`endif
        end
`ifdef INC_ARB_AUTOREPEAT_EN
        ST_REPEAT: begin
          if (!btn_in[j]) begin
            st_d[j] = ST_IDLE;
          end else if (tick) begin
            if (tcnt_q[j] == TCNT_W'(REPEAT_TICKS - 1)) begin
              tcnt_d[j]   = '0;
              pend_set[j] = 1'b1;
            end else begin
              tcnt_d[j] = tcnt_q[j] + TCNT_W'(1);
            end
          end
        end
`endif
        default: st_d[j] = ST_IDLE;
      endcase
    end
  end

  // Round-robin grant over registered pending bits, starting at rr_q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      cand = RR_W'((int'(rr_q) + k) % DIGITS);
      if (!gnt_vld && pend_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    rr_d = rr_q;
    if (gnt_vld) rr_d = (int'(gnt_idx) == DIGITS - 1) ? '0 : gnt_idx + RR_W'(1);
    // A new set on the digit being granted survives the clear.
    pend_d = pend_set | (pend_q & ~gnt_oh);
  end

  // Output decode
  always_comb begin
    any_active = 1'b0;
    any_repeat = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (st_q[j] != ST_IDLE) any_active = 1'b1;
`ifdef INC_ARB_AUTOREPEAT_EN
      if (st_q[j] == ST_REPEAT) any_repeat = 1'b1;
`endif
    end
  end

  assign inc_out    = inc_q;
  assign active_out = active_q;
  assign repeat_out = repeat_q;

endmodule

// File: tb/tb_inc_arbiter.sv
// Directed bench for inc_arbiter: table of per-cycle vectors plus a hold/auto-repeat sequence.
module tb_inc_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] btn_in;
  logic [3:0] inc_out;
  logic       active_out;
  logic       repeat_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inc_arbiter #(
    .DIGITS(4), .HOLD_TICKS(8), .REPEAT_TICKS(2), .TCNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .tick(tick),
    .inc_out(inc_out), .active_out(active_out), .repeat_out(repeat_out)
  );

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic [3:0] e_inc;
    logic       e_act;
  } vec_t;

  vec_t vt[$];

`ifdef INC_ARB_AUTOREPEAT_EN
  localparam int HDIG = 0;
  localparam int NTICK = 20;
  localparam int EXP_P = 7;
  localparam logic EXP_REP = 1'b1;
`else
  localparam int HDIG = 1;
  localparam int NTICK = 40;
  localparam int EXP_P = 1;
  localparam logic EXP_REP = 1'b0;
`endif

  int         pulses;
  int         other;
  int         onehot_bad;
  logic       rep_seen;
  logic [3:0] hb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, settle past it.
  task automatic cyc(input logic r, input logic [3:0] b, input logic t);
    reset  = r;
    btn_in = b;
    tick   = t;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] b, input logic [3:0] ei, input logic ea);
    vec_t v;
    v.rst = r; v.btn = b; v.e_inc = ei; v.e_act = ea;
    vt.push_back(v);
  endtask

  task automatic count_out();
    if (inc_out[HDIG]) pulses++;
    if ((inc_out & ~hb) != 4'b0) other++;
    if ($countones(inc_out) > 1) onehot_bad++;
    if (repeat_out) rep_seen = 1'b1;
  endtask

  initial begin
    reset = 1'b1; btn_in = 4'b0; tick = 1'b0;

    // Reset with btn 0 held; held button ignored until released and re-pressed.
    add(1, 4'b0001, 4'b0000, 0);
    add(1, 4'b0001, 4'b0000, 0);
    add(0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0001, 4'b0001, 1);
    add(0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 0);
    // Single press digit 2 held three cycles (rr=1).
    add(0, 4'b0100, 4'b0000, 0);
    add(0, 4'b0100, 4'b0100, 1);
    add(0, 4'b0100, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 0);
    // Digit 3 tap moves rr to 0.
    add(0, 4'b1000, 4'b0000, 0);
    add(0, 4'b0000, 4'b1000, 1);
    add(0, 4'b0000, 4'b0000, 0);
    // Contention: all four at once from rr=0.
    add(0, 4'b1111, 4'b0000, 0);
    add(0, 4'b1111, 4'b0001, 1);
    add(0, 4'b1111, 4'b0010, 1);
    add(0, 4'b1111, 4'b0100, 1);
    add(0, 4'b1111, 4'b1000, 1);
    add(0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 0);
    // Digit 1 tap moves rr to 2.
    add(0, 4'b0010, 4'b0000, 0);
    add(0, 4'b0000, 4'b0010, 1);
    add(0, 4'b0000, 4'b0000, 0);
    // rr=2, pend=0011, digit 3 rises as digit 0 is granted: order 0,1,3.
    add(0, 4'b0011, 4'b0000, 0);
    add(0, 4'b1011, 4'b0001, 1);
    add(0, 4'b1011, 4'b0010, 1);
    add(0, 4'b1011, 4'b1000, 1);
    add(0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 0);
    // rr wrapped 3->0: digit 0 before 3; pending served after release.
    add(0, 4'b1001, 4'b0000, 0);
    add(0, 4'b1001, 4'b0001, 1);
    add(0, 4'b0000, 4'b1000, 1);
    add(0, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].rst, vt[i].btn, 1'b0);
      chk($sformatf("vec%0d inc_out", i), 32'(inc_out), 32'(vt[i].e_inc));
      chk($sformatf("vec%0d active_out", i), 32'(active_out), 32'(vt[i].e_act));
      chk($sformatf("vec%0d repeat_out", i), 32'(repeat_out), 32'(1'b0));
    end

    // Hold one button with a tick every 16 cycles; last tick coincides with release.
    pulses = 0; other = 0; onehot_bad = 0; rep_seen = 1'b0;
    hb = 4'b0001 << HDIG;
    cyc(0, hb, 0); count_out();
    for (int t = 1; t <= NTICK; t++) begin
      for (int c = 0; c < 15; c++) begin
        cyc(0, hb, 0); count_out();
      end
      if (t == NTICK) cyc(0, 4'b0000, 1);
      else            cyc(0, hb, 1);
      count_out();
      if (t == 8) begin
        chk("repeat_out at 8th tick edge", 32'(repeat_out), 32'(1'b0));
        cyc(0, hb, 0); count_out();
        chk("repeat_out after 8th tick", 32'(repeat_out), 32'(EXP_REP));
      end
    end
    for (int c = 0; c < 10; c++) begin
      cyc(0, 4'b0000, 0); count_out();
    end
    chk("hold pulse count", 32'(pulses), 32'(EXP_P));
    chk("hold pulses on other digits", 32'(other), 32'd0);
    chk("inc_out one-hot", 32'(onehot_bad), 32'd0);
    chk("repeat_out seen", 32'(rep_seen), 32'(EXP_REP));
    chk("active_out after drain", 32'(active_out), 32'd0);
    chk("repeat_out after drain", 32'(repeat_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inc_arbiter.md
# inc_arbiter

Increment scheduler that sits between the button synchronizer and the per-digit BCD counters. Converts synchronized button levels into single-cycle increment pulses: one pulse per press plus optional hold-to-repeat auto-increment paced by the clock-scaler tick. Shares the increment path fairly when several buttons are held, issuing at most one increment per clock, round-robin across digits.

## Interface
- DIGITS, 4: number of digit buttons / counters served.
- HOLD_TICKS, 8: ticks a button must be held after the press before auto-repeat starts (≥1).
- REPEAT_TICKS, 2: ticks between auto-repeat increments (≥1).
- TCNT_W, 4: width of per-digit tick counter; must hold max(HOLD_TICKS, REPEAT_TICKS)-1.

Ports:
- clk  in  1  system clock; one clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_in  in  DIGITS  synchronized active-high button levels, bit j = digit j.
- tick  in  1  single-cycle pacing pulse from the clock scaler.
- inc_out  out  DIGITS  registered one-hot (or zero) increment pulse, one cycle wide.
- active_out  out  1  registered; 1 while any digit FSM is not IDLE.
- repeat_out  out  1  registered; 1 while any digit FSM is in REPEAT.

## Operation
- Per-digit FSM, states IDLE, HOLD, REPEAT; per-digit tick counter tcnt and pending bit pend; btn_prev register.
- IDLE: rising edge (btn_in[j]=1, btn_prev[j]=0) -> HOLD, tcnt=0, pend[j] set.
- HOLD: btn_in[j]=0 -> IDLE. On tick: if tcnt==HOLD_TICKS-1 -> REPEAT, tcnt=0, pend[j] set; else tcnt+1.
- REPEAT: btn_in[j]=0 -> IDLE. On tick: if tcnt==REPEAT_TICKS-1 -> tcnt=0, pend[j] set; else tcnt+1.
- Release has priority over tick in the same cycle; no pend set on release cycle.
- Pending bits already set at release are still served (a completed press always increments).
- Arbiter: rr pointer (log2 DIGITS bits, wraps at DIGITS). Each cycle grant first pend bit at index ≥ rr, wrapping; inc_out[g]=1 next cycle, pend[g] cleared, rr = (g+1) mod DIGITS. No pend -> inc_out=0, rr unchanged.
- Same-cycle set and grant-clear on one digit: set wins, pend stays 1 (one extra pulse follows).
- Set while pend already 1: event merged (dropped). Cannot occur when tick period ≥ DIGITS cycles.
- Reset: all FSMs IDLE, tcnt=0, pend=0, rr=0, inc_out=0, active_out=0, repeat_out=0, btn_prev=all ones (a button held through reset release is ignored until released and re-pressed).

## Timing
- Press sampled in cycle n -> pend set at end of n -> inc_out[j] high in cycle n+1 when uncontended.
- Worst-case press-to-pulse latency: DIGITS cycles (all digits pending).
- First auto-repeat pulse: HOLD_TICKS ticks after the press pulse, then one every REPEAT_TICKS ticks, each delayed ≤DIGITS cycles by arbitration.
- active_out/repeat_out reflect FSM state one cycle after the transition (registered).
- Never more than one inc_out bit high; consecutive cycles may pulse different digits.

## Configuration
- INC_ARB_AUTOREPEAT_EN defined: full behaviour above.
- Undefined: HOLD/REPEAT logic and tcnt removed; FSM is IDLE/PRESSED (leave on release only); exactly one pulse per press; repeat_out tied 0; HOLD_TICKS/REPEAT_TICKS ignored.

## Test plan
- Reset: assert reset 2 cycles with btn_in=4'b0001 held -> all outputs 0; after release, no inc_out until btn 0 released and pressed again.
- Single press: btn_in[2] rises cycle 10, held 3 cycles, no tick -> inc_out=4'b0100 in cycle 11 only; active_out 1 cycles 11-13, 0 from 14.
- Auto-repeat (macro defined, HOLD_TICKS=8, REPEAT_TICKS=2, tick every 16 cycles): hold btn 0 for 20 ticks -> 1 press pulse + 6 repeat pulses (ticks 8,10,...,18); repeat_out rises after 8th tick.
- Contention: btn_in 0->4'b1111 in one cycle, rr=0 -> inc_out 0001, 0010, 0100, 1000 on four consecutive cycles, then 0.
- Round-robin fairness: rr=2, pend=4'b0011 and digit 3 rises same cycle -> grant order digit 3 (pend visible next cycle rule: order 0,1,3 if set not yet visible); check rr wraps 3->0.
- Macro undefined: hold btn 1 for 40 ticks -> exactly one inc_out pulse, repeat_out stays 0.
